// File: rtl/uart_instr_server.sv
// uart_instr_server: UART responder that receives a 32-bit PC (4 bytes, LE, 8N1)
//   and returns the 32-bit ROM word at that address (4 bytes, LE, 8N1).
// Latency: first reply start bit leaves 3 clks after the 4th PC byte's stop sample.
// Backpressure: none; bytes that arrive during FETCH/TX_WORD are dropped silently.
// Ports: clk/reset (sync, active-high); rx/tx serial link (idle high);
//   rom_addr/rom_data synchronous ROM (data 1 clk after addr);
//   busy (request in flight); frame_err (1-clk pulse); req_count (completed requests).
module uart_instr_server #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          ADDR_W       = 10,
  parameter int          TIMEOUT_BITS = 32,
  parameter logic [31:0] NOP_WORD     = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              tx,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              busy,
  output logic              frame_err,
  output logic [15:0]       req_count
);

  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int TO_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W    = $clog2(TO_CLKS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CLKS - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [1:0] {M_IDLE, M_RX_WORD, M_FETCH, M_TX_WORD} m_state_e;

  // RX engine state
  logic             rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic             rx_vld_q, rx_vld_d, rx_bad_q, rx_bad_d;

  // Main FSM / TX state
  m_state_e         m_state_q, m_state_d;
  logic [31:0]      pc_q, pc_d, word_q, word_d;
  logic [1:0]       pc_cnt_q, pc_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             fetch_ph_q, fetch_ph_d;
  logic             tx_q, tx_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_bit_q, tx_bit_d;    // 0 = start, 1..8 = data, 9 = stop
  logic [1:0]       tx_byte_q, tx_byte_d;
  logic [15:0]      req_count_q, req_count_d;
  logic             frame_err_q, frame_err_d;

  logic [7:0] tx_cur;
  logic       pc_ok;

  assign tx_cur    = word_q[{tx_byte_q, 3'b000} +: 8];
  assign pc_ok     = (pc_q[1:0] == 2'b00) && ((pc_q >> (ADDR_W + 2)) == 32'd0);
  assign rom_addr  = pc_q[ADDR_W+1:2];
  assign tx        = tx_q;
  assign busy      = (m_state_q != M_IDLE);
  assign frame_err = frame_err_q;
  assign req_count = req_count_q;

  // RX bit engine; it keeps running in every main state, the main FSM decides
  // whether a finished byte is used.
  always_comb begin
    rx_s1_d    = rx;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_vld_d   = 1'b0;
    rx_bad_d   = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = R_START;
      end
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          // Line back high at mid-start: glitch, not a frame.
          rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_vld_d   = rx_s2_q;
          rx_bad_d   = !rx_s2_q;
          rx_state_d = R_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase
  end

  // Main request FSM, including the TX bit engine.
  always_comb begin
    m_state_d   = m_state_q;
    pc_d        = pc_q;
    pc_cnt_d    = pc_cnt_q;
    to_cnt_d    = to_cnt_q;
    fetch_ph_d  = fetch_ph_q;
    word_d      = word_q;
    tx_d        = tx_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_byte_d   = tx_byte_q;
    req_count_d = req_count_q;
    frame_err_d = 1'b0;
    case (m_state_q)
      M_IDLE: begin
        pc_cnt_d = 2'd0;
        if (rx_vld_q) begin
          pc_d      = {24'd0, rx_sh_q};
          pc_cnt_d  = 2'd1;
          to_cnt_d  = '0;
          m_state_d = M_RX_WORD;
        end else if (rx_bad_q) begin
          frame_err_d = 1'b1;
        end
      end
      M_RX_WORD: begin
        if (rx_vld_q) begin
          pc_d[{pc_cnt_q, 3'b000} +: 8] = rx_sh_q;
          pc_cnt_d = pc_cnt_q + 2'd1;
          to_cnt_d = '0;
          if (pc_cnt_q == 2'd3) begin
            fetch_ph_d = 1'b0;
            m_state_d  = M_FETCH;
          end
        end else if (rx_bad_q || (to_cnt_q == TO_LAST)) begin
          // Bad stop bit or idle too long: abandon the partial PC.
          frame_err_d = 1'b1;
          pc_cnt_d    = 2'd0;
          m_state_d   = M_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      M_FETCH: begin
        // Phase 0 presents the address, phase 1 sees the ROM data.
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          fetch_ph_d = 1'b0;
          word_d     = pc_ok ? rom_data : NOP_WORD;
          tx_d       = 1'b0;
          tx_cnt_d   = '0;
          tx_bit_d   = 4'd0;
          tx_byte_d  = 2'd0;
          m_state_d  = M_TX_WORD;
        end
      end
      M_TX_WORD: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            if (tx_byte_q == 2'd3) begin
              tx_d        = 1'b1;
              req_count_d = req_count_q + 16'd1;
              m_state_d   = M_IDLE;
            end else begin
              // Next start bit follows the stop bit directly.
              tx_byte_d = tx_byte_q + 2'd1;
              tx_bit_d  = 4'd0;
              tx_d      = 1'b0;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_d     = (tx_bit_q == 4'd8) ? 1'b1 : tx_cur[tx_bit_q[2:0]];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: m_state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= R_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_sh_q     <= 8'd0;
      rx_vld_q    <= 1'b0;
      rx_bad_q    <= 1'b0;
      m_state_q   <= M_IDLE;
      pc_q        <= 32'd0;
      pc_cnt_q    <= 2'd0;
      to_cnt_q    <= '0;
      fetch_ph_q  <= 1'b0;
      word_q      <= 32'd0;
      tx_q        <= 1'b1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 4'd0;
      tx_byte_q   <= 2'd0;
      req_count_q <= 16'd0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      rx_vld_q    <= rx_vld_d;
      rx_bad_q    <= rx_bad_d;
      m_state_q   <= m_state_d;
      pc_q        <= pc_d;
      pc_cnt_q    <= pc_cnt_d;
      to_cnt_q    <= to_cnt_d;
      fetch_ph_q  <= fetch_ph_d;
      word_q      <= word_d;
      tx_q        <= tx_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_byte_q   <= tx_byte_d;
      req_count_q <= req_count_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_uart_instr_server.sv
// Bench for uart_instr_server: drives PC requests over rx, decodes replies on tx,
// and compares against a ROM/address-rule reference model.
module tb_uart_instr_server;
  localparam int CPB = 32;
  localparam int AW  = 10;
  localparam int TOB = 32;
  // rx edge to R_START: 2 synchronizer flops + falling-edge register; then half a
  // bit to the start sample, 9 bit periods to the stop sample, and 3 clks to tx start.
  localparam int LAT = 3 + CPB / 2 + 9 * CPB + 3;

  logic          clk = 1'b0;
  logic          reset, rx, tx, busy, frame_err;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
  logic [15:0]   req_count;

  always #5 clk = ~clk;

  uart_instr_server #(
    .CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_BITS(TOB), .NOP_WORD(32'h00000013)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy), .frame_err(frame_err), .req_count(req_count)
  );

  logic [31:0] rom [0:(1<<AW)-1];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int cyc = 0;
  int ferr_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;

  int n_chk = 0;
  int n_pass = 0;
  int model_req = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

  // Reference: word-aligned PCs below 4*depth read the ROM, all others get the NOP.
  function automatic logic [31:0] model_reply(input logic [31:0] pc);
    if ((pc % 4) != 0 || pc >= 4 * (1 << AW)) return 32'h00000013;
    return rom[pc / 4];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, output int k);
    k  = cyc;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic send_request(input logic [31:0] pc, output int k);
    for (int j = 0; j < 4; j++) send_byte(pc[8*j +: 8], 1'b1, k);
  endtask

  task automatic recv_word(output logic [31:0] w, output int t0, output bit ok, output bit fr);
    ok = 0;
    fr = 1;
    w  = 32'd0;
    t0 = 0;
    for (int i = 0; i < 8 * 10 * CPB; i++) begin
      if (tx === 1'b0) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    if (ok) begin
      t0 = cyc;
      tick(CPB / 2);
      for (int j = 0; j < 4; j++) begin
        if (tx !== 1'b0) fr = 0;
        for (int i = 0; i < 8; i++) begin
          tick(CPB);
          w[8*j + i] = tx;
        end
        tick(CPB);
        if (tx !== 1'b1) fr = 0;
        if (j < 3) tick(CPB);
      end
    end
  endtask

  task automatic do_request(input logic [31:0] pc, input string tag);
    int k, t0, f0;
    logic [31:0] w;
    bit ok, fr;
    f0 = ferr_cnt;
    fork
      send_request(pc, k);
      recv_word(w, t0, ok, fr);
    join
    check({tag, " reply_seen"}, 32'(ok), 32'd1);
    check({tag, " word"}, w, model_reply(pc));
    check({tag, " framing"}, 32'(fr), 32'd1);
    check({tag, " latency"}, t0 - k, LAT);
    tick(CPB / 2 + 2);
    model_req++;
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " req_count"}, 32'(req_count), model_req);
    check({tag, " no_frame_err"}, ferr_cnt - f0, 32'd0);
  endtask

  initial begin
    int k, f0, t0;
    bit ok, tx_low;
    logic [31:0] pc;

    for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
    rom[5] = 32'hDEADBEEF;

    // Reset state, then a long idle line.
    reset = 1'b1;
    rx    = 1'b1;
    tick(5);
    check("rst tx", 32'(tx), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_err", 32'(frame_err), 32'd0);
    check("rst req_count", 32'(req_count), 32'd0);
    check("rst rom_addr", 32'(rom_addr), 32'd0);
    reset = 1'b0;
    tick(2000);
    check("idle tx", 32'(tx), 32'd1);
    check("idle busy", 32'(busy), 32'd0);
    check("idle req_count", 32'(req_count), 32'd0);
    check("idle frame_err", ferr_cnt, 32'd0);

    // ROM[5] via PC 0x14, then the two NOP cases.
    check("rom5 model", model_reply(32'h14), 32'hDEADBEEF);
    do_request(32'h00000014, "pc14");
    do_request(32'h00001002, "misaligned");
    do_request(32'h00010000, "out_of_range");

    // Partial PC followed by silence.
    f0 = ferr_cnt;
    send_byte(8'h08, 1'b1, k);
    send_byte(8'h00, 1'b1, k);
    tick(30 * CPB);
    check("timeout early busy", 32'(busy), 32'd1);
    check("timeout early err", ferr_cnt - f0, 32'd0);
    tick(3 * CPB);
    check("timeout err pulse", ferr_cnt - f0, 32'd1);
    check("timeout busy", 32'(busy), 32'd0);
    do_request(32'h00000000, "pc0_after_timeout");

    // Bad stop bit on the second PC byte, then a short glitch.
    f0 = ferr_cnt;
    send_byte(8'h10, 1'b1, k);
    send_byte(8'h00, 1'b0, k);
    tick(2);
    check("badstop err pulse", ferr_cnt - f0, 32'd1);
    check("badstop busy", 32'(busy), 32'd0);
    tick(2 * CPB);
    f0 = ferr_cnt;
    rx = 1'b0;
    tick(10);
    rx = 1'b1;
    tick(4 * CPB);
    check("glitch err", ferr_cnt - f0, 32'd0);
    check("glitch busy", 32'(busy), 32'd0);
    do_request({20'd0, 10'($urandom_range(0, 1023)), 2'b00}, "after_glitch");

    // Randomized mix of aligned, misaligned and out-of-range PCs.
    for (int r = 0; r < 3; r++) begin
      case ($urandom_range(0, 2))
        0:       pc = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
        1:       pc = {20'd0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
        default: pc = $urandom | 32'h00001000;
      endcase
      do_request(pc, "random");
    end

    // Reset in the middle of the second reply byte.
    fork
      send_request(32'h00000020, k);
      begin
        ok = 0;
        for (int i = 0; i < 8 * 10 * CPB; i++) begin
          if (tx === 1'b0) begin
            ok = 1;
            break;
          end
          tick(1);
        end
        check("midtx reply_seen", 32'(ok), 32'd1);
        t0 = cyc;
        tick(13 * CPB);
        reset = 1'b1;
        tick(1);
        check("midtx tx", 32'(tx), 32'd1);
        check("midtx busy", 32'(busy), 32'd0);
        check("midtx req_count", 32'(req_count), 32'd0);
        reset = 1'b0;
      end
    join
    model_req = 0;
    tx_low = 0;
    for (int i = 0; i < 40 * CPB; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) tx_low = 1;
      tick(1);
    end
    check("midtx no_partial", 32'(tx_low), 32'd0);
    do_request(32'h00000024, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
